// File: rtl/ara_xif_issue_queue.sv
// rtl/ara_xif_issue_queue.sv - XIF issue/register/commit queue feeding the Ara dispatcher
//
// Tracks vector instructions accepted on the core-v-xif issue port through
// their register (operand) and commit phases, and releases them in order to
// the dispatcher once committed with all required operands present.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   issue_*                       XIF issue request and decoder verdict
//   register_*                    XIF operand delivery (any order, by id)
//   commit_*                      XIF commit / targeted kill by id
//   disp_*                        in-order head entry towards the dispatcher
//   csr_done_i                    outstanding vset* resolved, lift serialisation
//   full_o, empty_o, count_o      occupancy

`timescale 1ns/1ps

module ara_xif_issue_queue #(
    parameter int DEPTH    = 4,
    parameter int ID_WIDTH = 4,
    parameter int NR_RS    = 2,
    parameter int XLEN     = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         issue_valid_i,
    output logic                         issue_ready_o,
    input  logic [31:0]                  issue_instr_i,
    input  logic [ID_WIDTH-1:0]          issue_id_i,
    input  logic                         issue_accept_i,
    input  logic                         issue_is_csr_i,
    input  logic [NR_RS-1:0]             issue_rs_read_i,
    input  logic                         register_valid_i,
    output logic                         register_ready_o,
    input  logic [ID_WIDTH-1:0]          register_id_i,
    input  logic [NR_RS*XLEN-1:0]        register_rs_i,
    input  logic [NR_RS-1:0]             register_rs_valid_i,
    input  logic                         commit_valid_i,
    input  logic [ID_WIDTH-1:0]          commit_id_i,
    input  logic                         commit_kill_i,
    output logic                         disp_valid_o,
    input  logic                         disp_ready_i,
    output logic [31:0]                  disp_instr_o,
    output logic [ID_WIDTH-1:0]          disp_id_o,
    output logic [NR_RS*XLEN-1:0]        disp_rs_o,
    input  logic                         csr_done_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    typedef logic [PTR_W-1:0] ptr_t;

    logic [DEPTH-1:0]    valid_q, valid_d, committed_q, committed_d, is_csr_q, is_csr_d;
    logic [31:0]         instr_q [DEPTH];
    logic [31:0]         instr_d [DEPTH];
    logic [ID_WIDTH-1:0] id_q    [DEPTH];
    logic [ID_WIDTH-1:0] id_d    [DEPTH];
    logic [NR_RS-1:0]    need_q  [DEPTH];
    logic [NR_RS-1:0]    need_d  [DEPTH];
    logic [NR_RS-1:0]    have_q  [DEPTH];
    logic [NR_RS-1:0]    have_d  [DEPTH];
    logic [XLEN-1:0]     rs_q    [DEPTH][NR_RS];
    logic [XLEN-1:0]     rs_d    [DEPTH][NR_RS];
    ptr_t                head_q, head_d, tail_q, tail_d;
    logic                csr_block_q, csr_block_d;
    logic [ID_WIDTH-1:0] csr_id_q, csr_id_d;

    logic                reg_hit, cmt_hit, kill_req, push, pop, kill, kill_csr;
    ptr_t                reg_slot, cmt_slot, kill_age;
    logic [CNT_W-1:0]    count;

    // Id lookup for register and commit ports, plus occupancy.
    always_comb begin
        reg_hit  = 1'b0;
        reg_slot = '0;
        cmt_hit  = 1'b0;
        cmt_slot = '0;
        count    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && id_q[i] == register_id_i) begin
                reg_hit  = 1'b1;
                reg_slot = ptr_t'(i);
            end
            if (valid_q[i] && id_q[i] == commit_id_i) begin
                cmt_hit  = 1'b1;
                cmt_slot = ptr_t'(i);
            end
            count = count + CNT_W'(valid_q[i]);
        end
    end

    assign count_o          = count;
    assign full_o           = (count == CNT_W'(DEPTH));
    assign empty_o          = (count == '0);
    assign kill_req         = commit_valid_i && commit_kill_i;
    assign issue_ready_o    = issue_valid_i && !full_o && !csr_block_q && !kill_req;
    assign register_ready_o = register_valid_i && reg_hit;
    assign disp_valid_o     = valid_q[head_q] && committed_q[head_q]
                              && (have_q[head_q] == need_q[head_q]);
    assign disp_instr_o     = instr_q[head_q];
    assign disp_id_o        = id_q[head_q];
    assign push             = issue_ready_o && issue_accept_i;
    assign pop              = disp_valid_o && disp_ready_i;
    assign kill             = kill_req && cmt_hit;
    // Age relative to head: the killed slot and everything at least as young goes.
    assign kill_age         = ptr_t'(cmt_slot - head_q);

    always_comb begin
        disp_rs_o = '0;
        for (int k = 0; k < NR_RS; k++) begin
            disp_rs_o[k*XLEN +: XLEN] = rs_q[head_q][k];
        end
    end

    always_comb begin
        valid_d     = valid_q;
        committed_d = committed_q;
        is_csr_d    = is_csr_q;
        instr_d     = instr_q;
        id_d        = id_q;
        need_d      = need_q;
        have_d      = have_q;
        rs_d        = rs_q;
        head_d      = head_q;
        tail_d      = tail_q;
        csr_block_d = csr_block_q;
        csr_id_d    = csr_id_q;
        kill_csr    = 1'b0;

        // Operand delivery; the head leaving this cycle is no longer a target.
        if (register_ready_o && !(pop && reg_slot == head_q)) begin
            for (int k = 0; k < NR_RS; k++) begin
                if (register_rs_valid_i[k] && need_q[reg_slot][k]) begin
                    rs_d[reg_slot][k]   = register_rs_i[k*XLEN +: XLEN];
                    have_d[reg_slot][k] = 1'b1;
                end
            end
        end

        if (commit_valid_i && !commit_kill_i && cmt_hit && !(pop && cmt_slot == head_q)) begin
            committed_d[cmt_slot] = 1'b1;
        end

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end

        if (kill) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && ptr_t'(ptr_t'(i) - head_q) >= kill_age) begin
                    valid_d[i] = 1'b0;
                    if (is_csr_q[i] && id_q[i] == csr_id_q) begin
                        kill_csr = 1'b1;
                    end
                end
            end
            // Killing a head that pops this same cycle leaves the queue empty,
            // so the tail must follow the advanced head.
            tail_d = (pop && cmt_slot == head_q) ? ptr_t'(head_q + 1'b1) : cmt_slot;
        end

        if (csr_done_i || kill_csr) begin
            csr_block_d = 1'b0;
        end

        if (push) begin
            valid_d[tail_q]     = 1'b1;
            committed_d[tail_q] = 1'b0;
            is_csr_d[tail_q]    = issue_is_csr_i;
            instr_d[tail_q]     = issue_instr_i;
            id_d[tail_q]        = issue_id_i;
            need_d[tail_q]      = issue_rs_read_i;
            have_d[tail_q]      = '0;
            tail_d              = tail_q + 1'b1;
            if (issue_is_csr_i) begin
                csr_block_d = 1'b1;
                csr_id_d    = issue_id_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q     <= '0;
            committed_q <= '0;
            is_csr_q    <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            csr_block_q <= 1'b0;
            csr_id_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                id_q[i]    <= '0;
                need_q[i]  <= '0;
                have_q[i]  <= '0;
                for (int k = 0; k < NR_RS; k++) begin
                    rs_q[i][k] <= '0;
                end
            end
        end else begin
            valid_q     <= valid_d;
            committed_q <= committed_d;
            is_csr_q    <= is_csr_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            csr_block_q <= csr_block_d;
            csr_id_q    <= csr_id_d;
            instr_q     <= instr_d;
            id_q        <= id_d;
            need_q      <= need_d;
            have_q      <= have_d;
            rs_q        <= rs_d;
        end
    end

endmodule

// File: tb/tb_ara_xif_issue_queue.sv
// tb/tb_ara_xif_issue_queue.sv - self-checking bench for ara_xif_issue_queue

`timescale 1ns/1ps

module tb_ara_xif_issue_queue;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         issue_valid_i, issue_ready_o, issue_accept_i, issue_is_csr_i;
    logic [31:0]  issue_instr_i;
    logic [3:0]   issue_id_i;
    logic [1:0]   issue_rs_read_i;
    logic         register_valid_i, register_ready_o;
    logic [3:0]   register_id_i;
    logic [127:0] register_rs_i;
    logic [1:0]   register_rs_valid_i;
    logic         commit_valid_i, commit_kill_i;
    logic [3:0]   commit_id_i;
    logic         disp_valid_o, disp_ready_i;
    logic [31:0]  disp_instr_o;
    logic [3:0]   disp_id_o;
    logic [127:0] disp_rs_o;
    logic         csr_done_i, full_o, empty_o;
    logic [2:0]   count_o;

    ara_xif_issue_queue #(.DEPTH(4), .ID_WIDTH(4), .NR_RS(2), .XLEN(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_accept_i(issue_accept_i), .issue_is_csr_i(issue_is_csr_i),
        .issue_rs_read_i(issue_rs_read_i),
        .register_valid_i(register_valid_i), .register_ready_o(register_ready_o),
        .register_id_i(register_id_i), .register_rs_i(register_rs_i),
        .register_rs_valid_i(register_rs_valid_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
        .commit_kill_i(commit_kill_i),
        .disp_valid_o(disp_valid_o), .disp_ready_i(disp_ready_i),
        .disp_instr_o(disp_instr_o), .disp_id_o(disp_id_o), .disp_rs_o(disp_rs_o),
        .csr_done_i(csr_done_i), .full_o(full_o), .empty_o(empty_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]   id;
        logic [31:0]  instr;
        logic [1:0]   need;
        logic [127:0] rs;
    } exp_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] instr;
        logic [1:0]  need;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [2:0]  exp_count;
        logic        exp_full;
    } vec_t;

    exp_t model[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_kill(input logic [3:0] id);
        int   idx;
        exp_t d;
        idx = -1;
        for (int i = 0; i < model.size(); i++) if (model[i].id == id && idx < 0) idx = i;
        if (idx >= 0) while (model.size() > idx) d = model.pop_back();
    endtask

    task automatic issue(input logic [3:0] id, input logic [31:0] instr,
                         input logic [1:0] need, input logic csr);
        exp_t e;
        issue_valid_i = 1'b1; issue_accept_i = 1'b1; issue_id_i = id;
        issue_instr_i = instr; issue_rs_read_i = need; issue_is_csr_i = csr;
        #1 chk("issue_ready", issue_ready_o, 1'b1);
        tick();
        issue_valid_i = 1'b0; issue_accept_i = 1'b0; issue_is_csr_i = 1'b0;
        e.id = id; e.instr = instr; e.need = need; e.rs = '0;
        model.push_back(e);
    endtask

    task automatic regdel(input logic [3:0] id, input logic [1:0] vld,
                          input logic [63:0] rs1, input logic [63:0] rs2, input logic exp_ready);
        exp_t t;
        register_valid_i = 1'b1; register_id_i = id;
        register_rs_valid_i = vld; register_rs_i = {rs2, rs1};
        #1 chk("register_ready", register_ready_o, exp_ready);
        tick();
        register_valid_i = 1'b0;
        for (int i = 0; i < model.size(); i++) begin
            if (model[i].id == id) begin
                t = model[i];
                if (vld[0] && t.need[0]) t.rs[63:0]   = rs1;
                if (vld[1] && t.need[1]) t.rs[127:64] = rs2;
                model[i] = t;
            end
        end
    endtask

    task automatic commit(input logic [3:0] id, input logic kill);
        commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
        tick();
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        if (kill) model_kill(id);
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 40 && model.size() > 0; c++) tick();
        chk(name, 128'(model.size()), 0);
    endtask

    // Dispatch scoreboard: inputs change just after posedge, so negedge sees
    // the handshake that the next posedge will complete.
    exp_t mon_e;
    always @(negedge clk_i) begin
        if (rst_ni && disp_valid_o && disp_ready_i) begin
            if (model.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_dispatch: got id %0h expected none", disp_id_o);
            end else begin
                mon_e = model.pop_front();
                chk("disp_id", disp_id_o, mon_e.id);
                chk("disp_instr", disp_instr_o, mon_e.instr);
                chk("disp_rs", disp_rs_o & {{64{mon_e.need[1]}}, {64{mon_e.need[0]}}},
                    mon_e.rs & {{64{mon_e.need[1]}}, {64{mon_e.need[0]}}});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    vec_t vecs[4];

    initial begin
        vecs[0] = '{id: 4'd1, instr: 32'h0000_1057, need: 2'b01, rs1: 64'h11, rs2: 64'h0,  exp_count: 3'd1, exp_full: 1'b0};
        vecs[1] = '{id: 4'd2, instr: 32'h0000_2057, need: 2'b10, rs1: 64'h0,  rs2: 64'h22, exp_count: 3'd2, exp_full: 1'b0};
        vecs[2] = '{id: 4'd3, instr: 32'h0000_3057, need: 2'b11, rs1: 64'h31, rs2: 64'h32, exp_count: 3'd3, exp_full: 1'b0};
        vecs[3] = '{id: 4'd4, instr: 32'h0000_4057, need: 2'b00, rs1: 64'h0,  rs2: 64'h0,  exp_count: 3'd4, exp_full: 1'b1};

        rst_ni = 1'b0;
        issue_valid_i = 0; issue_accept_i = 0; issue_is_csr_i = 0; issue_instr_i = 0;
        issue_id_i = 0; issue_rs_read_i = 0; register_valid_i = 0; register_id_i = 0;
        register_rs_i = 0; register_rs_valid_i = 0; commit_valid_i = 0; commit_id_i = 0;
        commit_kill_i = 0; disp_ready_i = 1'b1; csr_done_i = 0;
        tick(); tick();
        chk("rst_issue_ready", issue_ready_o, 1'b0);
        chk("rst_register_ready", register_ready_o, 1'b0);
        chk("rst_disp_valid", disp_valid_o, 1'b0);
        chk("rst_disp_instr", disp_instr_o, 0);
        chk("rst_disp_id", disp_id_o, 0);
        chk("rst_disp_rs", disp_rs_o, 0);
        chk("rst_full", full_o, 1'b0);
        chk("rst_empty", empty_o, 1'b1);
        chk("rst_count", count_o, 0);
        rst_ni = 1'b1;
        tick();

        // Fill to full from the table, then verify the refused push.
        for (int i = 0; i < 4; i++) begin
            issue(vecs[i].id, vecs[i].instr, vecs[i].need, 1'b0);
            chk("fill_count", count_o, vecs[i].exp_count);
            chk("fill_full", full_o, vecs[i].exp_full);
        end
        issue_valid_i = 1'b1; issue_accept_i = 1'b1; issue_id_i = 4'd9;
        #1 chk("full_issue_ready", issue_ready_o, 1'b0);
        tick();
        issue_valid_i = 1'b0; issue_accept_i = 1'b0;
        chk("full_no_push", count_o, 3'd4);
        for (int i = 0; i < 4; i++) begin
            regdel(vecs[i].id, 2'b11, vecs[i].rs1, vecs[i].rs2, 1'b1);
            commit(vecs[i].id, 1'b0);
        end
        drain("drain_fill");
        chk("fill_empty", empty_o, 1'b1);
        chk("fill_count0", count_o, 0);

        // Targeted kill rewinds the tail.
        issue(4'd5, 32'h5, 2'b00, 1'b0);
        issue(4'd6, 32'h6, 2'b00, 1'b0);
        issue(4'd7, 32'h7, 2'b00, 1'b0);
        issue_valid_i = 1'b1; issue_accept_i = 1'b1; issue_id_i = 4'd9;
        commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 4'd6;
        #1 chk("kill_issue_ready", issue_ready_o, 1'b0);
        tick();
        issue_valid_i = 1'b0; issue_accept_i = 1'b0; commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        model_kill(4'd6);
        chk("kill_count", count_o, 3'd1);
        issue(4'd8, 32'h8, 2'b00, 1'b0);
        chk("kill_count2", count_o, 3'd2);
        commit(4'd5, 1'b0);
        commit(4'd8, 1'b0);
        drain("drain_kill");

        // Out-of-order operand delivery.
        issue(4'd2, 32'h2222, 2'b11, 1'b0);
        regdel(4'd15, 2'b11, 64'hdead, 64'hbeef, 1'b0);
        regdel(4'd2, 2'b01, 64'hA, 64'h0, 1'b1);
        commit(4'd2, 1'b0);
        chk("partial_disp_valid0", disp_valid_o, 1'b0);
        tick();
        chk("partial_disp_valid1", disp_valid_o, 1'b0);
        tick();
        regdel(4'd2, 2'b10, 64'h0, 64'hB, 1'b1);
        chk("operands_complete", disp_valid_o, 1'b1);
        drain("drain_operands");

        // vset* serialisation.
        issue(4'd3, 32'h0000_7057, 2'b00, 1'b1);
        issue_valid_i = 1'b1; issue_accept_i = 1'b0; issue_id_i = 4'd4;
        commit_valid_i = 1'b1; commit_id_i = 4'd3;
        #1 chk("csr_block_ready0", issue_ready_o, 1'b0);
        tick();
        commit_valid_i = 1'b0;
        #1 chk("csr_block_ready1", issue_ready_o, 1'b0);
        drain("drain_csr");
        chk("csr_block_ready2", issue_ready_o, 1'b0);
        csr_done_i = 1'b1;
        #1 chk("csr_done_cycle_ready", issue_ready_o, 1'b0);
        tick();
        csr_done_i = 1'b0;
        #1 chk("csr_released_ready", issue_ready_o, 1'b1);
        issue_valid_i = 1'b0;
        tick();

        // Wrapped tail, kill of slot 3 covering slot 0.
        for (int i = 0; i < 3; i++) begin
            issue(4'(10 + i), 32'(32'h100 + i), 2'b00, 1'b0);
            commit(4'(10 + i), 1'b0);
        end
        drain("drain_prewrap");
        disp_ready_i = 1'b0;
        issue(4'd13, 32'h13, 2'b00, 1'b0);
        issue(4'd14, 32'h14, 2'b00, 1'b0);
        commit(4'd13, 1'b0);
        commit(4'd14, 1'b0);
        chk("wrap_count", count_o, 3'd2);
        commit(4'd13, 1'b1);
        chk("wrap_kill_count", count_o, 3'd0);
        chk("wrap_kill_empty", empty_o, 1'b1);
        disp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wrap_no_stale", disp_valid_o, 1'b0);
        end
        issue(4'd15, 32'h15, 2'b00, 1'b0);
        chk("wrap_reissue_count", count_o, 3'd1);
        commit(4'd15, 1'b0);
        drain("drain_wrap");

        // Kill of the head in the same cycle it pops.
        disp_ready_i = 1'b0;
        issue(4'd4, 32'h44, 2'b00, 1'b0);
        issue(4'd5, 32'h55, 2'b00, 1'b0);
        commit(4'd4, 1'b0);
        disp_ready_i = 1'b1;
        commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 4'd4;
        tick();
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        model.delete();
        chk("popkill_count", count_o, 3'd0);
        chk("popkill_empty", empty_o, 1'b1);
        issue(4'd6, 32'h66, 2'b00, 1'b0);
        chk("popkill_reissue_count", count_o, 3'd1);
        commit(4'd6, 1'b0);
        drain("drain_popkill");

        // Asynchronous reset with entries pending.
        disp_ready_i = 1'b0;
        issue(4'd1, 32'hA1, 2'b00, 1'b0);
        issue(4'd2, 32'hA2, 2'b00, 1'b0);
        issue(4'd3, 32'hA3, 2'b00, 1'b0);
        commit(4'd1, 1'b0);
        chk("prereset_count", count_o, 3'd3);
        rst_ni = 1'b0;
        #1;
        chk("async_rst_empty", empty_o, 1'b1);
        chk("async_rst_disp_valid", disp_valid_o, 1'b0);
        chk("async_rst_count", count_o, 3'd0);
        model.delete();
        tick();
        rst_ni = 1'b1;
        disp_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_no_dispatch", disp_valid_o, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
